// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron datapath stages: controller state
// encoding, accumulator width computation and the constants used by the
// ReLU / saturation output stage.
// -----------------------------------------------------------------------------
package neuron_pkg;

  // Controller states of one neuron evaluation.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_OUT
  } state_e;

  // Default configuration of a neuron stage.
  localparam int DEF_WEIGHT_N   = 5;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;

  // ReLU floor: any negative scaled sum is replaced by this value.
  localparam longint RELU_FLOOR = 0;

  // Accumulator width: full-precision product, one growth bit per doubling
  // of the operand count, plus one bit of headroom for the bias term.
  function automatic int acc_width(input int data_width, input int weight_n);
    return 2 * data_width + $clog2(weight_n) + 1;
  endfunction

  // Largest positive value representable in a signed word of width dw.
  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

endpackage

// File: rtl/neuron_fxp_mul.sv
// -----------------------------------------------------------------------------
// neuron_fxp_mul
// Registered full-precision signed multiplier with a product-valid flag.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clear_i  : synchronous clear of product and valid (new evaluation)
//   en_i     : operand pair accepted this edge
//   a_i, b_i : signed operands
//   prod_o   : registered product, 2*DATA_WIDTH signed
//   valid_o  : high for exactly the cycle after each accepted pair
// -----------------------------------------------------------------------------
module neuron_fxp_mul #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_i,
  input  logic                           en_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [DATA_WIDTH-1:0]   b_i,
  output logic signed [2*DATA_WIDTH-1:0] prod_o,
  output logic                           valid_o
);

  logic signed [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic                           valid_q;

  // Both operands are sign-extended to the product width before multiplying.
  assign prod_d = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);

  // NOTE: every flop gets an explicit reset value so the reset state is
  // defined without a clock; there is no memory array here to exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // A frozen cycle drops valid, so a held product is never added twice.
      valid_q <= en_i;
      if (en_i) prod_q <= prod_d;
    end
  end

  assign prod_o  = prod_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// One neuron: accumulates WEIGHT_N signed fixed-point products, adds a bias,
// applies ReLU and saturates the result back to DATA_WIDTH.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse, begins (or restarts) an evaluation
//   freeze    : upstream stall; an operand pair is accepted only while low
//   data_in   : signed activation
//   weight_in : signed weight paired with data_in
//   bias      : signed bias, sampled in the BIAS state
//   result    : ReLU'd, saturated output, held until the next completion
//   done_out  : one-cycle pulse when result has been updated
//   busy      : high in every state except IDLE
// -----------------------------------------------------------------------------
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int WEIGHT_N   = DEF_WEIGHT_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         freeze,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         done_out,
  output logic                         busy
);

  localparam int ACC_W = acc_width(DATA_WIDTH, WEIGHT_N);
  localparam int CNT_W = $clog2(WEIGHT_N + 1);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(RELU_FLOOR);

  state_e                         state_q, state_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic        [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [DATA_WIDTH-1:0]   result_q, result_d;
  logic                           done_q, done_d;

  logic                           accept;
  logic                           clear;
  logic                           last_pair;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                           prod_vld;
  logic signed [ACC_W-1:0]        scaled;

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  neuron_fxp_mul #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .en_i    (accept),
    .a_i     (data_in),
    .b_i     (weight_in),
    .prod_o  (prod),
    .valid_o (prod_vld)
  );

  // ---------------------------------------------------------------------------
  // Output / control decode (combinational, from current state)
  // ---------------------------------------------------------------------------
  // start takes priority over everything, so a pair offered in the same cycle
  // as start is never accepted.
  assign clear     = start;
  assign accept    = (state_q == ST_ACCUM) && !freeze && !start;
  assign last_pair = accept && (cnt_q == CNT_W'(WEIGHT_N - 1));
  assign busy      = (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next-state variables take their hold value first, so no path through
  // the case leaves them unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_ACCUM;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ACCUM: if (last_pair) state_d = ST_DRAIN;
        ST_DRAIN: state_d = ST_BIAS;
        ST_BIAS:  state_d = ST_OUT;
        ST_OUT:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  // Arithmetic shift truncates toward minus infinity.
  assign scaled = acc_q >>> FRAC_BITS;

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;

    // The product registered on the previous accept is folded in one edge
    // later; DRAIN exists to catch the final one.
    if (prod_vld) acc_d = acc_d + ACC_W'(prod);
    if (state_q == ST_BIAS) acc_d = acc_d + (ACC_W'(bias) <<< FRAC_BITS);
    if (accept) cnt_d = cnt_q + CNT_W'(1);

    if (state_q == ST_OUT && !start) begin
      done_d = 1'b1;
      if (scaled < SAT_LO)      result_d = DATA_WIDTH'(SAT_LO);
      else if (scaled > SAT_HI) result_d = DATA_WIDTH'(SAT_HI);
      else                      result_d = DATA_WIDTH'(scaled);
    end

    // A restart discards any partial sum.
    if (start) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result   = result_q;
  assign done_out = done_q;

endmodule
